// File: rtl/tl_tx_err_msg_sender.sv
// Drains the RX error-handler FIFO and replays each entry as a TLP header
// on the TX path, one DW per beat, after winning TX arbitration.
module tl_tx_err_msg_sender #(
    parameter int MSG_WIDTH = 128,
    parameter int DW_WIDTH  = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_empty_flag,
    input  logic [MSG_WIDTH-1:0] i_tlp_msg,
    input  logic                 i_ur_cpl_valid,
    output logic                 o_msg_trans_en,
    output logic                 o_read_ptr_incr,
    output logic                 o_tx_req,
    input  logic                 i_tx_gnt,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic [DW_WIDTH-1:0]  o_tx_data,
    output logic                 o_tx_sop,
    output logic                 o_tx_eop,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_sent_cnt
);

    // Handshake: a beat transfers on a rising edge where o_tx_valid && i_tx_ready;
    // while valid is high and ready is low, data/sop/eop hold their values.

    typedef enum logic [1:0] {IDLE, FETCH, REQ, SEND} state_t;

    state_t                 state_q;
    logic [MSG_WIDTH-1:0]   hold_msg_q;
    logic                   is_cpl_q;
    logic [1:0]             idx_q;
    logic                   msg_trans_en_q;
    logic                   read_ptr_incr_q;
    logic                   tx_req_q;
    logic                   tx_valid_q;
    logic                   busy_q;
    logic [CNT_WIDTH-1:0]   sent_cnt_q;

    logic [1:0]             last_idx;
    logic [MSG_WIDTH-1:0]   shifted_msg;

    // Completions carry a 3DW header; the fourth DW of the entry is dropped.
    assign last_idx    = is_cpl_q ? 2'd2 : 2'd3;
    assign shifted_msg = hold_msg_q << (DW_WIDTH * idx_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= IDLE;
            hold_msg_q      <= '0;
            is_cpl_q        <= 1'b0;
            idx_q           <= 2'd0;
            msg_trans_en_q  <= 1'b0;
            read_ptr_incr_q <= 1'b0;
            tx_req_q        <= 1'b0;
            tx_valid_q      <= 1'b0;
            busy_q          <= 1'b0;
            sent_cnt_q      <= '0;
        end else begin
            msg_trans_en_q  <= 1'b0;
            read_ptr_incr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!i_empty_flag) begin
                        state_q         <= FETCH;
                        msg_trans_en_q  <= 1'b1;
                        read_ptr_incr_q <= 1'b1;
                        busy_q          <= 1'b1;
                    end
                end
                FETCH: begin
                    hold_msg_q <= i_tlp_msg;
                    is_cpl_q   <= i_ur_cpl_valid;
                    idx_q      <= 2'd0;
                    tx_req_q   <= 1'b1;
                    state_q    <= REQ;
                end
                REQ: begin
                    if (i_tx_gnt) begin
                        tx_valid_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    // Grant is no longer looked at: a started TLP always completes.
                    if (i_tx_ready) begin
                        if (idx_q == last_idx) begin
                            sent_cnt_q <= sent_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                            tx_req_q   <= 1'b0;
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_msg_trans_en  = msg_trans_en_q;
    assign o_read_ptr_incr = read_ptr_incr_q;
    assign o_tx_req        = tx_req_q;
    assign o_tx_valid      = tx_valid_q;
    assign o_busy          = busy_q;
    assign o_sent_cnt      = sent_cnt_q;
    assign o_tx_data       = tx_valid_q ? shifted_msg[MSG_WIDTH-1 -: DW_WIDTH] : '0;
    assign o_tx_sop        = tx_valid_q && (idx_q == 2'd0);
    assign o_tx_eop        = tx_valid_q && (idx_q == last_idx);

endmodule

// File: tb/tb_tl_tx_err_msg_sender.sv
// Bench for tl_tx_err_msg_sender: FIFO model, directed entries, beat scoreboard.
module tb_tl_tx_err_msg_sender;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_empty_flag = 1'b1;
    logic [127:0] i_tlp_msg = '0;
    logic         i_ur_cpl_valid = 1'b0;
    logic         o_msg_trans_en;
    logic         o_read_ptr_incr;
    logic         o_tx_req;
    logic         i_tx_gnt = 1'b0;
    logic         o_tx_valid;
    logic         i_tx_ready = 1'b0;
    logic [31:0]  o_tx_data;
    logic         o_tx_sop;
    logic         o_tx_eop;
    logic         o_busy;
    logic [7:0]   o_sent_cnt;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int beats_acc = 0;

    logic [33:0]  exp_q[$];
    logic [127:0] fifo_msg[$];
    logic         fifo_cpl[$];

    tl_tx_err_msg_sender dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_empty_flag(i_empty_flag),
        .i_tlp_msg(i_tlp_msg), .i_ur_cpl_valid(i_ur_cpl_valid),
        .o_msg_trans_en(o_msg_trans_en), .o_read_ptr_incr(o_read_ptr_incr),
        .o_tx_req(o_tx_req), .i_tx_gnt(i_tx_gnt), .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data), .o_tx_sop(o_tx_sop),
        .o_tx_eop(o_tx_eop), .o_busy(o_busy), .o_sent_cnt(o_sent_cnt)
    );

    // clock / watchdog
    always #5 i_clk = ~i_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // show-ahead FIFO model: head visible whenever non-empty, popped on read_ptr_incr
    always @(posedge i_clk) begin
        if (o_read_ptr_incr && fifo_msg.size() > 0) begin
            void'(fifo_msg.pop_front());
            void'(fifo_cpl.pop_front());
            pops++;
        end
        i_empty_flag   <= (fifo_msg.size() == 0);
        i_tlp_msg      <= (fifo_msg.size() > 0) ? fifo_msg[0] : '0;
        i_ur_cpl_valid <= (fifo_cpl.size() > 0) ? fifo_cpl[0] : 1'b0;
    end

    // monitor: compare each accepted beat, and check stability while stalled
    logic        stall_q = 1'b0;
    logic [33:0] held_beat = '0;
    always @(negedge i_clk) begin
        logic [33:0] exp_beat;
        if (!i_rst && o_tx_valid) begin
            if (stall_q)
                check("stall_stable", {o_tx_data, o_tx_sop, o_tx_eop}, held_beat);
            if (i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {o_tx_data, o_tx_sop, o_tx_eop}, 34'h0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", {o_tx_data, o_tx_sop, o_tx_eop}, exp_beat);
                end
                beats_acc++;
                stall_q = 1'b0;
            end else begin
                stall_q   = 1'b1;
                held_beat = {o_tx_data, o_tx_sop, o_tx_eop};
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic push_entry(input logic [127:0] msg, input logic cpl);
        int n;
        logic [31:0] dw;
        n = cpl ? 3 : 4;
        fifo_msg.push_back(msg);
        fifo_cpl.push_back(cpl);
        for (int k = 0; k < n; k++) begin
            dw = msg[127 - 32*k -: 32];
            exp_q.push_back({dw, (k == 0), (k == n - 1)});
        end
    endtask

    task automatic wait_sent(input logic [7:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (o_sent_cnt !== target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, o_sent_cnt, target);
    endtask

    function automatic logic [127:0] all_outs();
        return {o_msg_trans_en, o_read_ptr_incr, o_tx_req, o_tx_valid, o_tx_data,
                o_tx_sop, o_tx_eop, o_busy, o_sent_cnt};
    endfunction

    initial begin
        int n;
        int base;
        int idle;
        logic started;

        // reset state
        tick(3);
        check("reset_outputs", all_outs(), '0);
        i_rst = 1'b0;

        // 1: reset mid-SEND abandons the TLP
        i_tx_gnt   = 1'b1;
        i_tx_ready = 1'b1;
        push_entry(128'h01010101_02020202_03030303_04040404, 1'b0);
        n = 0;
        while (beats_acc < 2 && n < 50) begin tick(1); n++; end
        check("midsend_reached", (beats_acc >= 2), 1'b1);
        i_rst = 1'b1;
        tick(1);
        check("reset_midsend_outputs", all_outs(), '0);
        tick(1);
        i_rst = 1'b0;
        exp_q.delete();
        base = beats_acc;
        tick(8);
        check("no_beats_after_reset", beats_acc, base);
        check("busy_after_reset", o_busy, 1'b0);

        // 2: 4DW message, with latency and pop check
        base = pops;
        push_entry(128'h11111111_22222222_33333333_44444444, 1'b0);
        n = 0;
        while (i_empty_flag && n < 10) begin tick(1); n++; end
        tick(1);
        check("fetch_pop", {o_read_ptr_incr, o_msg_trans_en, o_busy}, 3'b111);
        tick(1);
        check("req_state", {o_tx_req, o_tx_valid, o_read_ptr_incr}, 3'b100);
        tick(1);
        check("latency_first_beat", {o_tx_valid, o_tx_sop}, 2'b11);
        wait_sent(8'd1, 20, "msg_sent_cnt");
        check("msg_one_pop", pops - base, 1);

        // 3: 3DW completion, DW3 never sent
        push_entry(128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 1'b1);
        wait_sent(8'd2, 20, "cpl_sent_cnt");
        tick(2);
        check("cpl_drained", exp_q.size(), 0);

        // 4: backpressure on beat 2
        base = beats_acc;
        push_entry(128'h55555555_66666666_77777777_88888888, 1'b0);
        n = 0;
        while (beats_acc != base + 1 && n < 20) begin tick(1); n++; end
        i_tx_ready = 1'b0;
        tick(5);
        check("stalled_beat2", {o_tx_valid, o_tx_data, o_tx_sop, o_tx_eop}, {1'b1, 32'h66666666, 2'b00});
        i_tx_ready = 1'b1;
        wait_sent(8'd3, 20, "bp_sent_cnt");

        // 5: arbitration wait
        i_tx_gnt = 1'b0;
        push_entry(128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000, 1'b0);
        n = 0;
        while (!o_tx_req && n < 10) begin tick(1); n++; end
        for (int c = 0; c < 10; c++) begin
            tick(1);
            check("no_gnt_hold", {o_tx_req, o_tx_valid}, 2'b10);
        end
        i_tx_gnt = 1'b1;
        tick(1);
        check("gnt_to_beat", {o_tx_valid, o_tx_sop, o_tx_data}, {2'b11, 32'h9999AAAA});
        wait_sent(8'd4, 20, "arb_sent_cnt");

        // 6: back-to-back entries, one idle cycle between TLPs
        base = pops;
        idle = 0;
        started = 1'b0;
        push_entry(128'h0000000A_0000000B_0000000C_0000000D, 1'b0);
        push_entry(128'h1000000A_1000000B_1000000C_1000000D, 1'b1);
        push_entry(128'h2000000A_2000000B_2000000C_2000000D, 1'b0);
        n = 0;
        while (n < 100) begin
            tick(1);
            n++;
            if (o_sent_cnt == 8'd7) break;
            if (o_busy) started = 1'b1;
            else if (started) idle++;
        end
        check("b2b_sent_cnt", o_sent_cnt, 8'd7);
        check("b2b_idle_gaps", idle, 2);
        check("b2b_pops", pops - base, 3);

        // counter wrap: fill to all-ones, then one more TLP
        for (int k = 0; k < 248; k++)
            push_entry({32'hC0DE0000 + k, 32'h1, 32'h2, 32'h3}, 1'b1);
        wait_sent(8'hFF, 3000, "cnt_all_ones");
        push_entry(128'hFEEDFACE_CAFEBABE_DEADBEEF_01234567, 1'b0);
        wait_sent(8'h00, 50, "cnt_wrap");
        tick(3);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_idle", o_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
